// File: rtl/io_key_input.sv
// io_key_input: memory-mapped push-button peripheral on the CPU I/O bus.
// Each raw key goes through a 2-flop synchronizer and a per-key debouncer.
// A debounced press (0->1) sets a sticky EVENT bit and bumps an 8-bit COUNT.
// A level irq is raised when an EVENT bit is set and its CTRL mask bit is set.
//
// Ports:
//   clock   - system clock
//   resetn  - asynchronous active-low reset
//   key_n   - [NKEYS] raw buttons, active low, asynchronous to clock
//   addr    - [32] CPU byte address; only addr[7:2] is decoded
//   datain  - [32] CPU store data
//   we      - store strobe, already qualified by the I/O decoder
//   rdata   - [32] combinational read data for addr, unmapped bits 0
//   irq     - level interrupt request, |(EVENT & CTRL)
//
// Register map (addr[7:0]): 0x90 STATE (RO), 0x94 EVENT (W1C),
//                           0x98 COUNT (RO), 0x9C CTRL (R/W)

// Per-key synchronizer + debouncer.
//   stable - debounced level, 1 = pressed
//   press  - one-cycle strobe, high in the cycle before stable rises
module io_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic stable,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // sync_pipe[1] is the synchronized, inverted key (1 = pressed)
    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;
    logic          accept;

    // A mismatch that has survived a full count is accepted this edge.
    assign accept = (sync_pipe[1] != stable) && (cnt == CNT_MAX);
    assign press  = accept && sync_pipe[1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_pipe <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], ~key_n};
            if (sync_pipe[1] == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_pipe[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module io_key_input #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [NKEYS-1:0] key_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      datain,
    input  logic             we,
    output logic [31:0]      rdata,
    output logic             irq
);
    // word indices seen on addr[7:2]
    localparam logic [5:0] REG_STATE = 6'h24;  // 0x90
    localparam logic [5:0] REG_EVENT = 6'h25;  // 0x94
    localparam logic [5:0] REG_COUNT = 6'h26;  // 0x98
    localparam logic [5:0] REG_CTRL  = 6'h27;  // 0x9C

    typedef struct packed {
        logic             we;
        logic [5:0]       word;
        logic [NKEYS-1:0] data;
    } io_req_t;

    io_req_t          req;
    logic [NKEYS-1:0] stable;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] event_q;
    logic [NKEYS-1:0] ctrl_q;
    logic [NKEYS-1:0] clr;
    logic [7:0]       count_q;
    logic [7:0]       press_cnt;

    assign req.we   = we;
    assign req.word = addr[7:2];
    assign req.data = datain[NKEYS-1:0];

    genvar k;
    generate
        for (k = 0; k < NKEYS; k++) begin : g_key
            io_key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock  (clock),
                .resetn (resetn),
                .key_n  (key_n[k]),
                .stable (stable[k]),
                .press  (press[k])
            );
        end
    endgenerate

    assign clr = (req.we && req.word == REG_EVENT) ? req.data : '0;

    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < NKEYS; i++) begin
            press_cnt = press_cnt + 8'(press[i]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            event_q <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            // press is OR-ed in after the clear so a same-edge press survives
            event_q <= (event_q & ~clr) | press;
            count_q <= count_q + press_cnt;
            if (req.we && req.word == REG_CTRL) begin
                ctrl_q <= req.data;
            end
        end
    end

    assign irq = |(event_q & ctrl_q);

    always_comb begin
        rdata = '0;
        case (req.word)
            REG_STATE: rdata[NKEYS-1:0] = stable;
            REG_EVENT: rdata[NKEYS-1:0] = event_q;
            REG_COUNT: rdata[7:0]       = count_q;
            REG_CTRL:  rdata[NKEYS-1:0] = ctrl_q;
            default:   rdata = '0;
        endcase
    end
endmodule

// File: doc/io_key_input.md
# io_key_input

Memory-mapped push-button input peripheral that sits behind the CPU data-memory/IO decoder in the I/O window (addr[7]=1). It is the device end of the single-cycle computer's I/O port bus: it answers CPU loads with key state and captures press events, and it accepts CPU stores for event clearing and control. Raw keys are synchronized and debounced, and press events are latched as sticky bits. An interrupt-request level is produced for the CPU.

## Interface
- NKEYS, 4: number of keys, 1..8.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a key change is accepted, ≥2. The counter width is ceil(log2(DEBOUNCE_CYCLES)).
- clock  in  1  system clock; the same clock that drives dmem_clk-side I/O registers.
- resetn  in  1  asynchronous, active-low reset.
- key_n  in  NKEYS  raw board push-buttons, active low, asynchronous to clock.
- addr  in  32  CPU byte address. Only addr[7:2] is decoded.
- datain  in  32  CPU store data.
- we  in  1  write strobe, already gated to the I/O window and the write phase by the decoder.
- rdata  out  32  read data for the current addr. Combinational. Unmapped bits are 0.
- irq  out  1  level interrupt request.

## Operation
- Register map, decoded from addr[7:2]:
  - 0x90 STATE (RO): bit i = debounced key i is pressed.
  - 0x94 EVENT (R/W1C): sticky press events.
  - 0x98 COUNT (RO): 8-bit press counter in bits [7:0].
  - 0x9C CTRL (R/W): bits [NKEYS-1:0] are the irq enable mask.
  - Any other address: rdata=0, writes are ignored.
- Synchronizer: 2 flops per key, inverted so that sync=1 means pressed. Reset value 0.
- Debounce per key:
  - When sync≠stable, cnt increments.
  - When sync==stable, cnt clears to 0.
  - When cnt==DEBOUNCE_CYCLES-1 and a mismatch is still present, stable←sync and cnt←0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Press event: stable goes 0→1. The release edge (1→0) sets no event.
- EVENT update each cycle: EVENT ← (EVENT & ~clr) | press.
  - clr = datain[NKEYS-1:0] when we and addr is 0x9C−8 (=0x94), else 0.
  - A press event and a clear of the same bit in the same cycle: the press wins, and the bit stays 1.
- COUNT increments by popcount(press) each cycle and wraps modulo 256. It is not writable.
- CTRL is written from datain[NKEYS-1:0] on we at 0x9C.
- irq = |(EVENT & CTRL mask). It is combinational from registers and has no extra latency.
- Reads have no side effects.
- Reset values:
  - sync, stable, cnt, EVENT, COUNT, CTRL are all 0.
  - Therefore rdata=0 for every address and irq=0.
- Reset mid-debounce discards the partial count. After reset, a key still held is accepted again only after a full debounce and counts as a new press.

## Timing
- Single clock domain. All state updates on the rising edge of clock.
- Latency from key_n change:
  - The change is sampled at edge 0 and sync reflects it after edge 1.
  - cnt counts on edges 2..DEBOUNCE_CYCLES.
  - stable and EVENT update on edge DEBOUNCE_CYCLES+1.
  - STATE, EVENT, COUNT and irq are visible immediately after that edge.
- A CPU store takes effect at the edge where we=1. A read of the same register in the next cycle returns the new value.
- rdata follows addr combinationally within the same cycle.
- Simultaneous presses on several keys in one cycle: all corresponding EVENT bits set, and COUNT adds the number of keys pressed.
- COUNT at 255 plus one press gives 0. At 255 plus two presses it gives 1.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NKEYS=4.
- Reset: hold resetn=0, drive key_n=4'b0000 → rdata=0 at 0x90/0x94/0x98/0x9C and irq=0. Release reset → STATE=0xF after 5 edges and EVENT=0xF.
- Glitch: drop key_n[0] for 3 cycles → STATE, EVENT and COUNT unchanged. Hold for 10 cycles → STATE=0x1 at edge 5, EVENT=0x1, COUNT=1. Release → STATE=0, EVENT stays 0x1.
- W1C and priority: with EVENT=0x3, store 0x1 to 0x94 → EVENT=0x2. Make key1 press land on the same edge as a store of 0x2 → EVENT bit1 stays 1.
- IRQ: CTRL=0x4, press key0 → irq=0. Press key2 → irq=1 the same cycle EVENT[2] sets. Clear with 0x4 → irq=0.
- Counter wrap: generate 255 presses, then press keys 0 and 1 simultaneously → COUNT=1.
- Reset mid-debounce: assert resetn=0 for 1 cycle at cnt=2 while key3 is held → no event during reset. EVENT[3]=1 exactly 5 edges after release, and COUNT=1.
